sdp_fifo_ctrl: RTL

SDP_FIFO_CTRL -- requirements
Module: sdp_fifo_ctrl

---
 rtl/sdp_fifo_pkg.sv | 28 ++
 rtl/sdpram_if.sv | 28 ++
 rtl/sdp_fifo_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sdp_fifo_pkg.sv
// sdp_fifo_pkg: shared helpers for the simple-dual-port FIFO controller.
//   addr_width() - RAM address width for a given FIFO depth
//   strb_width() - write-strobe width for the attached RAM
//   ptr_t        - wide pointer container used by ptr_inc()
//   ptr_inc()    - pointer increment wrapping modulo 2**(aw+1)
package sdp_fifo_pkg;

    localparam int unsigned PTR_MAX_WIDTH = 32;

    typedef logic [PTR_MAX_WIDTH-1:0] ptr_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned strb_width(input int unsigned data_width,
                                               input int unsigned byte_write);
        return (byte_write != 0) ? data_width / 8 : 1;
    endfunction

    // One extra bit above the RAM address distinguishes full from empty.
    function automatic ptr_t ptr_inc(input ptr_t ptr, input int unsigned aw);
        ptr_t mask;
        mask = (ptr_t'(1) << (aw + 1)) - ptr_t'(1);
        return (ptr + ptr_t'(1)) & mask;
    endfunction

endpackage

// File: rtl/sdpram_if.sv
// sdpram_if: simple dual-port RAM interface (port A write, port B read).
//   addra/dina/wena - write address, data and per-lane write strobe
//   addrb/renb      - read address and read enable
//   doutb/dvalb     - read data and its valid, returned after the RAM latency
// Modports: sdp_m (controller side), sdp_s (RAM side).
interface sdpram_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned STRB_WIDTH = 1
);
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic [STRB_WIDTH-1:0] wena;
    logic [ADDR_WIDTH-1:0] addrb;
    logic                  renb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  dvalb;

    modport sdp_m (
        output addra, dina, wena, addrb, renb,
        input  doutb, dvalb
    );

    modport sdp_s (
        input  addra, dina, wena, addrb, renb,
        output doutb, dvalb
    );
endinterface

// File: rtl/sdp_fifo_ctrl.sv
// sdp_fifo_ctrl: FIFO controller in front of an external simple dual-port RAM.
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   push, push_data      - write request and data
//   pop                  - read request
//   pop_data, pop_valid  - read data returned with the RAM's own latency
//   full, empty          - level == MEM_DEPTH / level == 0
//   almost_full          - level >= AFULL_THRESH
//   level                - stored entry count
//   m                    - master side of the RAM interface
//   ovf_err, unf_err     - sticky push-while-full / pop-while-empty flags,
//                          present only when SDP_FIFO_ERR_EN is defined
module sdp_fifo_ctrl
    import sdp_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned BYTE_WRITE   = 0,
    parameter int unsigned AFULL_THRESH = MEM_DEPTH - 4,
    localparam int unsigned ADDR_WIDTH  = addr_width(MEM_DEPTH),
    localparam int unsigned STRB_WIDTH  = strb_width(DATA_WIDTH, BYTE_WRITE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    sdpram_if.sdp_m               m
`ifdef SDP_FIFO_ERR_EN
    ,
    output logic                  ovf_err,
    output logic                  unf_err
`endif
);

    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

    if (MEM_DEPTH < 4 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sdp_fifo_ctrl: MEM_DEPTH must be a power of two >= 4");
    end

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0] level_q, level_d;
    logic [PTR_WIDTH-1:0] outst_q, outst_d;
    logic                 push_acc, pop_acc, rd_counted;

    assign full        = (level_q == PTR_WIDTH'(MEM_DEPTH));
    assign empty       = (level_q == '0);
    assign almost_full = (level_q >= PTR_WIDTH'(AFULL_THRESH));
    assign level       = level_q;

    // rst_n gating keeps the RAM strobes quiet while reset is held.
    assign push_acc = push & ~full & rst_n;
    assign pop_acc  = pop & ~empty & rst_n;

    assign m.addra = wr_ptr_q[ADDR_WIDTH-1:0];
    assign m.dina  = push_data;
    assign m.wena  = {STRB_WIDTH{push_acc}};
    assign m.addrb = rd_ptr_q[ADDR_WIDTH-1:0];
    assign m.renb  = pop_acc;

    // A dvalb with nothing outstanding belongs to a read issued before reset.
    assign rd_counted = m.dvalb & (outst_q != '0);
    assign pop_valid  = rd_counted;
    assign pop_data   = m.doutb;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        outst_d  = outst_q;
        if (push_acc) begin
            wr_ptr_d = PTR_WIDTH'(ptr_inc(ptr_t'(wr_ptr_q), ADDR_WIDTH));
        end
        if (pop_acc) begin
            rd_ptr_d = PTR_WIDTH'(ptr_inc(ptr_t'(rd_ptr_q), ADDR_WIDTH));
        end
        unique case ({pop_acc, rd_counted})
            2'b10:   outst_d = outst_q + PTR_WIDTH'(1);
            2'b01:   outst_d = outst_q - PTR_WIDTH'(1);
            default: outst_d = outst_q;
        endcase
        level_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            outst_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            outst_q  <= outst_d;
        end
    end

`ifdef SDP_FIFO_ERR_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (push & full);
            unf_q <= unf_q | (pop & empty);
        end
    end

    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
`endif

endmodule
